// File: rtl/sink_checker.sv
// sink_checker: NoC traffic sink with ready throttling, dest/order checking and counters
module sink_checker #(
    parameter int         WIDTH        = 32,
    parameter int         N            = 16,
    parameter int         N_ADDR_WIDTH = $clog2(N),
    parameter logic [7:0] ID           = 8'd0,
    parameter int         NODE         = 1,
    parameter int         READY_PERIOD = 4,
    parameter int         READY_DUTY   = 3,
    parameter int         NUM_EXPECT   = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_in,
    output logic             ready_out,
    output logic             done,
    output logic             err_dest,
    output logic             err_order,
    output logic [31:0]      rx_count,
    output logic [15:0]      err_count
);
    localparam int NAW = N_ADDR_WIDTH;
    localparam int CW  = WIDTH - 2 * NAW - 8;
    localparam int PW  = READY_PERIOD > 1 ? $clog2(READY_PERIOD) : 1;
    localparam logic [NAW-1:0] NODE_A = NODE[NAW-1:0];
    localparam logic [PW:0]    DUTY   = READY_DUTY[PW:0];
    localparam logic [PW-1:0]  LAST   = PW'(READY_PERIOD - 1);
    localparam logic [31:0]    EXP    = NUM_EXPECT;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   phase_q, phase_d;
    logic            ready_q, ready_d;
    logic [31:0]     rx_q, rx_d;
    logic [15:0]     errc_q, errc_d;
    logic            err_dest_q, err_dest_d;
    logic            err_order_q, err_order_d;
    logic            seen_q [N];
    logic            seen_d [N];
    logic [CW-1:0]   last_q [N];
    logic [CW-1:0]   last_d [N];

    logic [NAW-1:0]  s, d;
    logic [CW-1:0]   cnt, diff;
    logic            fire, dest_ok, dest_bad, order_bad;
    logic            unused;

    assign s         = data_in[WIDTH-1 -: NAW];
    assign d         = data_in[WIDTH-1-NAW -: NAW];
    assign cnt       = data_in[CW-1:0];
    assign unused    = ^{data_in[WIDTH-1-2*NAW -: 8], ID};
    assign fire      = valid_in && ready_q;
    assign dest_ok   = d == NODE_A;
    assign diff      = cnt - last_q[s];
    assign dest_bad  = fire && !dest_ok;
    assign order_bad = fire && dest_ok && seen_q[s] && (diff == '0 || diff[CW-1]);

    // next-state: FSM, throttle phase, counters, sticky flags and per-source order table
    always_comb begin
        rx_d        = fire && rx_q != '1 ? rx_q + 32'd1 : rx_q;
        errc_d      = (dest_bad || order_bad) && errc_q != '1 ? errc_q + 16'd1 : errc_q;
        err_dest_d  = err_dest_q || dest_bad;
        err_order_d = err_order_q || order_bad;
        state_d     = state_q == IDLE ? RUN :
                      (state_q == RUN && fire && rx_d >= EXP) ? DONE : state_q;
        phase_d     = state_q == IDLE ? '0 : phase_q == LAST ? '0 : phase_q + 1'b1;
        ready_d     = state_q != IDLE && ({1'b0, phase_q} < DUTY);
        seen_d      = seen_q;
        last_d      = last_q;
        if (fire && dest_ok) begin
            seen_d[s] = 1'b1;
            last_d[s] = cnt;
        end
    end

    // state registers, all cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            phase_q     <= '0;
            ready_q     <= 1'b0;
            rx_q        <= '0;
            errc_q      <= '0;
            err_dest_q  <= 1'b0;
            err_order_q <= 1'b0;
            seen_q      <= '{default: 1'b0};
            last_q      <= '{default: '0};
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            ready_q     <= ready_d;
            rx_q        <= rx_d;
            errc_q      <= errc_d;
            err_dest_q  <= err_dest_d;
            err_order_q <= err_order_d;
            seen_q      <= seen_d;
            last_q      <= last_d;
        end
    end

    assign ready_out = ready_q;
    assign done      = state_q == DONE;
    assign err_dest  = err_dest_q;
    assign err_order = err_order_q;
    assign rx_count  = rx_q;
    assign err_count = errc_q;
endmodule

// File: tb/tb_sink_checker.sv
// tb_sink_checker: directed checks of throttle, dest/order checking, wrap, done and reset
module tb_sink_checker;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] data_in = '0;
    logic        valid_in = 1'b0;
    logic        ready_out, done, err_dest, err_order;
    logic [31:0] rx_count;
    logic [15:0] err_count;
    int tests = 0;
    int fails = 0;

    sink_checker #(.NUM_EXPECT(4)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in),
        .ready_out(ready_out), .done(done), .err_dest(err_dest), .err_order(err_order),
        .rx_count(rx_count), .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // waits (bounded) for ready, then presents one flit for exactly one posedge
    task automatic send(input logic [3:0] s, input logic [3:0] d, input logic [15:0] c);
        int n = 0;
        @(negedge clk);
        while (!ready_out && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready", {31'd0, ready_out}, 32'd1);
        data_in  = {s, d, 8'h00, c};
        valid_in = 1'b1;
        @(posedge clk);
        #1 valid_in = 1'b0;
    endtask

    logic [31:0] rx_exp [1:8];

    initial begin
        rx_exp = '{0, 0, 1, 2, 3, 3, 4, 5};
        // reset and throttle start-up
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {31'd0, ready_out}, 32'd0);
        chk("rst_rx", rx_count, 32'd0);
        chk("rst_errc", {16'd0, err_count}, 32'd0);
        chk("rst_flags", {28'd0, done, err_dest, err_order, ready_out}, 32'd0);
        @(negedge clk) rst = 1'b0;
        chk("idle_ready0", {31'd0, ready_out}, 32'd0);
        @(negedge clk);
        chk("idle_ready1", {31'd0, ready_out}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("throttle%0d", i), {31'd0, ready_out}, {31'd0, (i % 4) != 3});
        end
        // in-order traffic with gaps
        send(3, 1, 16'd1);
        send(3, 1, 16'd2);
        send(3, 1, 16'd5);
        chk("inorder_rx", rx_count, 32'd3);
        chk("inorder_errc", {16'd0, err_count}, 32'd0);
        chk("inorder_flags", {29'd0, done, err_dest, err_order}, 32'd0);
        // repeated counter, fourth flit also reaches done
        send(3, 1, 16'd7);
        chk("done_at4", {31'd0, done}, 32'd1);
        send(3, 1, 16'd7);
        chk("order_err", {31'd0, err_order}, 32'd1);
        chk("order_errc", {16'd0, err_count}, 32'd1);
        send(3, 1, 16'd8);
        chk("order_recover", {16'd0, err_count}, 32'd1);
        chk("order_rx", rx_count, 32'd6);
        // dest error must not update the order table
        send(5, 1, 16'd2);
        send(5, 2, 16'd3);
        chk("dest_err", {31'd0, err_dest}, 32'd1);
        chk("dest_rx", rx_count, 32'd8);
        chk("dest_errc", {16'd0, err_count}, 32'd2);
        send(5, 1, 16'd3);
        chk("dest_follow", {16'd0, err_count}, 32'd2);
        // wrap-around legal, half-range jump illegal
        send(7, 1, 16'hFFFF);
        send(7, 1, 16'h0000);
        chk("wrap_ok", {16'd0, err_count}, 32'd2);
        send(9, 1, 16'h0005);
        send(9, 1, 16'h8005);
        chk("half_err", {16'd0, err_count}, 32'd3);
        chk("wrap_rx", rx_count, 32'd13);
        chk("done_sticky", {31'd0, done}, 32'd1);
        // asynchronous reset mid-cycle
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("async_rx", rx_count, 32'd0);
        chk("async_errc", {16'd0, err_count}, 32'd0);
        chk("async_flags", {28'd0, done, err_dest, err_order, ready_out}, 32'd0);
        // valid held high: only ready cycles transfer, table was cleared
        @(negedge clk) rst = 1'b0;
        valid_in = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            data_in = {4'd3, 4'd1, 8'h00, 16'(k)};
            @(negedge clk);
            chk($sformatf("bp_rx%0d", k), rx_count, rx_exp[k]);
            chk($sformatf("bp_done%0d", k), {31'd0, done}, {31'd0, k >= 7});
        end
        chk("bp_errc", {16'd0, err_count}, 32'd0);
        valid_in = 1'b0;
        repeat (3) @(negedge clk);
        chk("bp_done_hold", {31'd0, done}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("final_rst_done", {31'd0, done}, 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
